// File: rtl/fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_issue_ctrl
//
// Issue stage in front of the FPU. Requests (op, A, B, tag) arrive over a
// valid/ready port and are buffered in a DEPTH-entry FIFO. One request is
// in flight at a time. For each request the block:
//   1. drives the operands and op onto the FPU,
//   2. holds fpu_start (the FPU's active-high Reset) for START_HOLD cycles,
//   3. waits for a rising edge on fpu_done,
//   4. returns the captured result and the request's tag over valid/ready.
//
// Optional feature macro: FPU_TIMEOUT_EN
//   defined   : a watchdog aborts the wait after TIMEOUT_CYCLES cycles with no
//               Done rise. The response then carries rsp_timeout=1 and
//               rsp_result=0.
//   undefined : the wait is unbounded and rsp_timeout is tied to 0.
//
// Parameters
//   PRECISION       operand/result width
//   TAG_W           request tag width
//   DEPTH           request FIFO entries (power of 2, >= 2)
//   START_HOLD      cycles fpu_start stays high per issue (>= 1)
//   TIMEOUT_CYCLES  watchdog limit in WAIT cycles (FPU_TIMEOUT_EN only)
//
// Ports
//   Clk, Reset                clock (rising edge), async active-low reset
//   req_valid/ready           request handshake; req_ready = FIFO not full
//   req_op/a/b/tag            request payload (op: 00 add 01 sub 10 mul 11 div)
//   fpu_a/b/op                operands and operation presented to the FPU
//   fpu_start                 start pulse, wired to the FPU Reset input
//   fpu_result, fpu_done      FPU result and completion flag
//   rsp_valid/ready           response handshake
//   rsp_result/tag/timeout    response payload
//   busy                      FSM active or requests still queued
// -----------------------------------------------------------------------------
module fpu_issue_ctrl #(
    parameter int PRECISION      = 32,
    parameter int TAG_W          = 4,
    parameter int DEPTH          = 4,
    parameter int START_HOLD     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [PRECISION-1:0] req_a,
    input  logic [PRECISION-1:0] req_b,
    input  logic [TAG_W-1:0]     req_tag,
    output logic [PRECISION-1:0] fpu_a,
    output logic [PRECISION-1:0] fpu_b,
    output logic [1:0]           fpu_op,
    output logic                 fpu_start,
    input  logic [PRECISION-1:0] fpu_result,
    input  logic                 fpu_done,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [PRECISION-1:0] rsp_result,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 rsp_timeout,
    output logic                 busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // FIFO storage and bookkeeping
    logic [PRECISION-1:0] fifo_a   [DEPTH];
    logic [PRECISION-1:0] fifo_b   [DEPTH];
    logic [1:0]           fifo_op  [DEPTH];
    logic [TAG_W-1:0]     fifo_tag [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 push, pop, fifo_empty;

    logic [TAG_W-1:0]     cur_tag;
    logic [HOLD_W-1:0]    hold_cnt;
    logic                 done_q, done_rise, wait_exit;
    logic                 start_nxt, valid_nxt;

    // Registered count only: a pop while full does not open a slot this cycle.
    assign req_ready  = (count != CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = req_valid && req_ready;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign busy       = (state != IDLE) || !fifo_empty;

    // Edge detect so a Done level left over from a previous op is ignored.
    assign done_rise  = fpu_done && !done_q;

`ifdef FPU_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
    logic              timeout_q;

    assign timeout_hit = (state == WAIT) && !done_rise &&
                         (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign wait_exit   = done_rise || timeout_hit;
    assign rsp_timeout = timeout_q;

    // Counter is zero in every other state, so it restarts on each WAIT entry.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + WAIT_W'(1) : '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_q <= 1'b1;
        end else if (state == RESP && rsp_ready) begin
            timeout_q <= 1'b0;
        end
    end
`else
    assign wait_exit   = done_rise;
    assign rsp_timeout = 1'b0;
`endif

    // FIFO write side: payload only, no reset needed.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_a[wr_ptr]   <= req_a;
            fifo_b[wr_ptr]   <= req_b;
            fifo_op[wr_ptr]  <= req_op;
            fifo_tag[wr_ptr] <= req_tag;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and registered-output decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = START;
            START:   if (hold_cnt == HOLD_W'(START_HOLD - 1)) state_nxt = WAIT;
            WAIT:    if (wait_exit) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // fpu_start drives the FPU reset pin, so it comes straight from a flop.
        start_nxt = (state_nxt == START);
        valid_nxt = (state_nxt == RESP);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fpu_start <= 1'b0;
            rsp_valid <= 1'b0;
            hold_cnt  <= '0;
            done_q    <= 1'b0;
        end else begin
            fpu_start <= start_nxt;
            rsp_valid <= valid_nxt;
            hold_cnt  <= (state == START) ? hold_cnt + HOLD_W'(1) : '0;
            done_q    <= fpu_done;
        end
    end

    // Operand registers load on pop and stay put until the next pop, which
    // keeps them stable through START and WAIT.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fpu_a      <= '0;
            fpu_b      <= '0;
            fpu_op     <= '0;
            cur_tag    <= '0;
            rsp_result <= '0;
            rsp_tag    <= '0;
        end else begin
            if (pop) begin
                fpu_a   <= fifo_a[rd_ptr];
                fpu_b   <= fifo_b[rd_ptr];
                fpu_op  <= fifo_op[rd_ptr];
                cur_tag <= fifo_tag[rd_ptr];
            end
            if (state == WAIT && wait_exit) begin
                // A watchdog exit has no Done rise; the result is forced to 0.
                rsp_result <= done_rise ? fpu_result : '0;
                rsp_tag    <= cur_tag;
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpu_issue_ctrl
//
// Directed bench for fpu_issue_ctrl. A behavioural FPU model responds to each
// start pulse after a programmable delay. A table of four requests covers the
// four operations with hand-computed IEEE-754 results. Hand-written sequences
// then cover FIFO fill, response back-pressure, Done held high across two ops,
// reset during WAIT and (when FPU_TIMEOUT_EN is defined) the watchdog.
// -----------------------------------------------------------------------------
module tb_fpu_issue_ctrl;

    localparam int PRECISION      = 32;
    localparam int TAG_W          = 4;
    localparam int DEPTH          = 4;
    localparam int START_HOLD     = 2;
    localparam int TIMEOUT_CYCLES = 64;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 req_valid, req_ready;
    logic [1:0]           req_op;
    logic [PRECISION-1:0] req_a, req_b;
    logic [TAG_W-1:0]     req_tag;
    logic [PRECISION-1:0] fpu_a, fpu_b;
    logic [1:0]           fpu_op;
    logic                 fpu_start;
    logic [PRECISION-1:0] fpu_result;
    logic                 fpu_done;
    logic                 rsp_valid, rsp_ready;
    logic [PRECISION-1:0] rsp_result;
    logic [TAG_W-1:0]     rsp_tag;
    logic                 rsp_timeout;
    logic                 busy;

    fpu_issue_ctrl #(
        .PRECISION(PRECISION), .TAG_W(TAG_W), .DEPTH(DEPTH),
        .START_HOLD(START_HOLD), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_start(fpu_start),
        .fpu_result(fpu_result), .fpu_done(fpu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- FPU model ----------------
    bit                   model_stall  = 1'b0;
    bit                   model_manual = 1'b0;
    bit                   model_fixed  = 1'b0;
    int                   model_delay  = 3;
    logic [PRECISION-1:0] model_result = '0;
    logic [PRECISION-1:0] cap_a = '0, cap_b = '0;
    logic [1:0]           cap_op = '0;
    bit                   m_armed = 1'b0;
    int                   m_cnt = 0;

    initial begin
        fpu_done   = 1'b0;
        fpu_result = 32'hDEADBEEF;
        forever begin
            @(posedge Clk); #1;
            if (!Reset) begin
                m_armed = 1'b0;
                if (!model_manual) begin
                    fpu_done   = 1'b0;
                    fpu_result = 32'hDEADBEEF;
                end
            end else if (!model_manual) begin
                if (fpu_done) begin
                    fpu_done   = 1'b0;
                    fpu_result = 32'hDEADBEEF;
                end
                if (fpu_start) begin
                    m_armed = 1'b1;
                    m_cnt   = 0;
                    cap_a   = fpu_a;
                    cap_b   = fpu_b;
                    cap_op  = fpu_op;
                end else if (m_armed) begin
                    m_cnt++;
                    if (m_cnt >= model_delay && !model_stall) begin
                        fpu_done   = 1'b1;
                        fpu_result = model_fixed ? model_result : (cap_a ^ cap_b);
                        m_armed    = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    typedef struct {
        logic [TAG_W-1:0]     tag;
        logic [PRECISION-1:0] res;
        logic                 to;
    } rsp_t;

    rsp_t rq[$];
    int   n_starts = 0;
    int   start_rise_cyc = -1;
    int   start_len = 0;
    bit   start_prev = 1'b0;

    always @(negedge Clk) begin
        if (!Reset) begin
            start_len  = 0;
            start_prev = 1'b0;
        end else begin
            if (fpu_start) begin
                if (!start_prev) begin
                    n_starts++;
                    start_rise_cyc = cyc;
                end
                start_len++;
            end else if (start_prev) begin
                check("start_pulse_len", 64'(start_len), 64'(START_HOLD));
                start_len = 0;
            end
            start_prev = fpu_start;
            if (rsp_valid && rsp_ready)
                rq.push_back('{tag: rsp_tag, res: rsp_result, to: rsp_timeout});
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1;
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, output int acc);
        req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 300; i++) begin
            if (req_ready) begin
                @(posedge Clk); #1;
                acc = cyc;
                break;
            end
            @(posedge Clk); #1;
        end
        req_valid = 1'b0;
        if (acc < 0) begin
            checks++; failures++;
            $display("FAIL push_wait: tag %0d never accepted", tag);
        end
    endtask

    task automatic get_rsp(input int budget, output rsp_t r, output bit ok);
        ok = 1'b0;
        r  = '{tag: '0, res: '0, to: 1'b0};
        for (int i = 0; i < budget; i++) begin
            if (rq.size() > 0) begin
                r  = rq.pop_front();
                ok = 1'b1;
                break;
            end
            @(posedge Clk); #1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL rsp_wait: no response within %0d cycles", budget);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_fpu_start"},   64'(fpu_start),   64'd0);
        check({pfx, "_rsp_valid"},   64'(rsp_valid),   64'd0);
        check({pfx, "_rsp_timeout"}, 64'(rsp_timeout), 64'd0);
        check({pfx, "_busy"},        64'(busy),        64'd0);
        check({pfx, "_req_ready"},   64'(req_ready),   64'd1);
        check({pfx, "_fpu_a"},       64'(fpu_a),       64'd0);
        check({pfx, "_fpu_b"},       64'(fpu_b),       64'd0);
        check({pfx, "_fpu_op"},      64'(fpu_op),      64'd0);
        check({pfx, "_rsp_result"},  64'(rsp_result),  64'd0);
        check({pfx, "_rsp_tag"},     64'(rsp_tag),     64'd0);
    endtask

    // ---------------- test ----------------
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        int          delay;
        logic [31:0] res;
    } vec_t;

    vec_t vt[4];

    initial begin
        rsp_t r;
        bit   ok;
        int   acc;
        int   s0;
        int   cnt;

        vt[0] = '{op: 2'b00, a: 32'h3FC00000, b: 32'h3FC00000, tag: 4'd5,  delay: 20, res: 32'h40400000}; // 1.5+1.5=3.0
        vt[1] = '{op: 2'b01, a: 32'h40400000, b: 32'h3F800000, tag: 4'd9,  delay: 3,  res: 32'h40000000}; // 3.0-1.0=2.0
        vt[2] = '{op: 2'b10, a: 32'h40000000, b: 32'h40400000, tag: 4'd12, delay: 1,  res: 32'h40C00000}; // 2.0*3.0=6.0
        vt[3] = '{op: 2'b11, a: 32'h3F800000, b: 32'h40800000, tag: 4'd15, delay: 7,  res: 32'h3E800000}; // 1.0/4.0=0.25

        Reset = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        rsp_ready = 1'b1;
        #1;
        check_reset_outputs("por");
        tick(3);
        Reset = 1'b1;
        tick(2);

        // Table: one request at a time, each with its own FPU latency.
        model_fixed = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s0 = n_starts;
            model_delay  = vt[i].delay;
            model_result = vt[i].res;
            push(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, acc);
            get_rsp(200, r, ok);
            if (ok) begin
                check($sformatf("vec%0d_tag", i),     64'(r.tag), 64'(vt[i].tag));
                check($sformatf("vec%0d_result", i),  64'(r.res), 64'(vt[i].res));
                check($sformatf("vec%0d_timeout", i), 64'(r.to),  64'd0);
            end
            check($sformatf("vec%0d_fpu_a", i),   64'(cap_a),  64'(vt[i].a));
            check($sformatf("vec%0d_fpu_b", i),   64'(cap_b),  64'(vt[i].b));
            check($sformatf("vec%0d_fpu_op", i),  64'(cap_op), 64'(vt[i].op));
            check($sformatf("vec%0d_n_starts", i), 64'(n_starts - s0), 64'd1);
            check($sformatf("vec%0d_start_latency", i), 64'(start_rise_cyc), 64'(acc + 1));
        end
        model_fixed = 1'b0;
        tick(2);

        // Fill: five pushes against a stalled FPU leave one in flight and four queued.
        model_stall = 1'b1;
        model_delay = 2;
        s0 = n_starts;
        for (int i = 0; i < 5; i++)
            push(2'(i), 32'h10000000 + 32'(i), 32'h000000F0 + 32'(i), 4'(i), acc);
        check("fill_req_ready", 64'(req_ready), 64'd0);
        check("fill_busy",      64'(busy),      64'd1);
        req_op = 2'b00; req_a = 32'hAAAAAAAA; req_b = 32'h55555555; req_tag = 4'hE; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("full_stays_full", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        model_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            get_rsp(100, r, ok);
            if (ok) begin
                check($sformatf("order%0d_tag", i), 64'(r.tag), 64'(i));
                check($sformatf("order%0d_result", i), 64'(r.res),
                      64'((32'h10000000 + 32'(i)) ^ (32'h000000F0 + 32'(i))));
            end
        end
        tick(20);
        check("fill_no_extra_rsp", 64'(rq.size()), 64'd0);
        check("fill_n_starts",     64'(n_starts - s0), 64'd5);
        check("fill_idle_busy",    64'(busy), 64'd0);

        // Back-pressure: response must hold and nothing new issues while stalled.
        rsp_ready = 1'b0;
        model_delay = 3;
        push(2'b01, 32'h12345678, 32'h0F0F0F0F, 4'd7, acc);
        push(2'b10, 32'hCAFEF00D, 32'h00FF00FF, 4'd8, acc);
        cnt = 0;
        while (!rsp_valid && cnt < 100) begin
            tick(1);
            cnt++;
        end
        check("bp_rsp_valid_seen", 64'(rsp_valid), 64'd1);
        s0 = n_starts;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("bp_rsp_valid",  64'(rsp_valid),  64'd1);
            check("bp_rsp_result", 64'(rsp_result), 64'(32'h12345678 ^ 32'h0F0F0F0F));
            check("bp_rsp_tag",    64'(rsp_tag),    64'd7);
            check("bp_fpu_start",  64'(fpu_start),  64'd0);
        end
        check("bp_no_new_start", 64'(n_starts - s0), 64'd0);
        rsp_ready = 1'b1;
        get_rsp(100, r, ok);
        if (ok) check("bp_first_tag", 64'(r.tag), 64'd7);
        get_rsp(100, r, ok);
        if (ok) begin
            check("bp_second_tag",    64'(r.tag), 64'd8);
            check("bp_second_result", 64'(r.res), 64'(32'hCAFEF00D ^ 32'h00FF00FF));
        end
        tick(2);

        // Done held high across two ops: the second op needs a fresh rise.
        model_manual = 1'b1;
        fpu_done = 1'b0;
        s0 = n_starts;
        push(2'b00, 32'h3F800000, 32'h3F800000, 4'd1, acc);
        push(2'b00, 32'h40000000, 32'h40000000, 4'd2, acc);
        tick(6);
        fpu_result = 32'h11111111;
        fpu_done   = 1'b1;
        get_rsp(50, r, ok);
        if (ok) begin
            check("hold_first_tag",    64'(r.tag), 64'd1);
            check("hold_first_result", 64'(r.res), 64'h11111111);
        end
        fpu_result = 32'h22222222;
        tick(12);
        check("hold_no_double_capture", 64'(rsp_valid), 64'd0);
        check("hold_rq_empty",          64'(rq.size()), 64'd0);
        check("hold_second_issued",     64'(n_starts - s0), 64'd2);
        fpu_done = 1'b0;
        tick(1);
        fpu_done = 1'b1;
        get_rsp(50, r, ok);
        if (ok) begin
            check("hold_second_tag",    64'(r.tag), 64'd2);
            check("hold_second_result", 64'(r.res), 64'h22222222);
        end
        fpu_done = 1'b0;
        fpu_result = 32'hDEADBEEF;
        model_manual = 1'b0;
        tick(3);

        // Reset in WAIT with a second request queued.
        model_stall = 1'b1;
        push(2'b11, 32'h01010101, 32'h10101010, 4'd3, acc);
        push(2'b00, 32'h02020202, 32'h20202020, 4'd4, acc);
        tick(6);
        check("rst_busy_before", 64'(busy), 64'd1);
        #2;
        Reset = 1'b0;
        #1;
        check_reset_outputs("rst");
        tick(2);
        Reset = 1'b1;
        model_stall = 1'b0;
        s0 = n_starts;
        tick(40);
        check("rst_no_response", 64'(rq.size()), 64'd0);
        check("rst_no_issue",    64'(n_starts - s0), 64'd0);
        check("rst_idle",        64'(busy), 64'd0);
        push(2'b01, 32'h0000FFFF, 32'h00FF0000, 4'd6, acc);
        get_rsp(100, r, ok);
        if (ok) check("rst_fresh_tag", 64'(r.tag), 64'd6);
        tick(2);

`ifdef FPU_TIMEOUT_EN
        // Watchdog: Done never rises.
        model_stall = 1'b1;
        push(2'b10, 32'h3F800000, 32'h3F800000, 4'd13, acc);
        cnt = 0;
        while (!fpu_start && cnt < 20) begin tick(1); cnt++; end
        cnt = 0;
        while (fpu_start && cnt < 20) begin tick(1); cnt++; end
        cnt = 0;
        while (!rsp_valid && cnt < 200) begin tick(1); cnt++; end
        check("wd_cycles", 64'(cnt), 64'(TIMEOUT_CYCLES));
        get_rsp(10, r, ok);
        if (ok) begin
            check("wd_timeout", 64'(r.to),  64'd1);
            check("wd_result",  64'(r.res), 64'd0);
            check("wd_tag",     64'(r.tag), 64'd13);
        end
        model_stall = 1'b0;
        tick(3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
